ccff_chain_driver: RTL and testbench
====================================

Name: ccff_chain_driver

Overview:
Drives the configuration-chain side of the fabric tiles: accepts configuration words from a host stream, serializes them onto `ccff_head`, and gates chain shifting with `ccff_shift_en`. While new bits enter the chain, it captures the old contents emerging on `ccff_tail` and returns them as a readback word stream. It also owns `IO_ISOL_N`, holding the IO tiles isolated until a full chain load completes. It sits between the SoC-side programming interface and the first tile's `ccff_head`, with the last tile's `ccff_tail` looped back.

Parameters:
- CHAIN_LEN, default 9: total configuration bits in the chain, ≥1.
- WORD_W, default 8: width of host and readback words, ≥1.
- CNT_W, default $clog2(CHAIN_LEN+1): bit-counter width (derived).

Ports:
- prog_clk  in  1  programming clock; all logic is on the rising edge.
- pReset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a chain load; sampled only in IDLE.
- s_data  in  WORD_W  config word; bit 0 is shifted first.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  driver accepts s_data this cycle.
- m_data  out  WORD_W  readback word; bit 0 is the first bit captured.
- m_valid  out  1  readback word is valid.
- m_ready  in  1  consumer accepts m_data.
- ccff_head  out  1  serial bit into the chain.
- ccff_shift_en  out  1  chain flops shift on this prog_clk edge.
- ccff_tail  in  1  chain output (combinational from the last chain flop).
- IO_ISOL_N  out  1  0 = IOs isolated.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes.
- bit_cnt  out  CNT_W  number of bits shifted so far in the current load.

Behaviour:
- Reset (pReset_n=0 at a clock edge):
  - state=IDLE.
  - All outputs 0, including IO_ISOL_N=0, m_valid=0, ccff_shift_en=0, ccff_head=0.
  - Internal counters and registers cleared.
  - Reset mid-load aborts immediately; the chain is left partially shifted and no done pulse is produced.
- States: IDLE, FETCH, SHIFT, DRAIN, DONE.
- IDLE:
  - start=1 → FETCH. IO_ISOL_N←0 on the same edge; bit_cnt←0.
  - start in any other state is ignored.
- FETCH:
  - s_ready=1.
  - On s_valid: load s_data into the shift register, set word_bit←0, go to SHIFT.
- SHIFT:
  - ccff_head=sreg[0] (combinational from the register).
  - ccff_shift_en=1 unless stalled.
  - On each enabled cycle:
    - rb[word_bit]←ccff_tail, sampled before the edge, so the captured bit is the one leaving the chain.
    - sreg shifts right.
    - word_bit++ and bit_cnt++.
  - A word ends on the cycle where word_bit==WORD_W-1 or bit_cnt==CHAIN_LEN-1.
  - Stall rule: on a word-ending cycle, shift only if the output register is empty or being drained this cycle (m_valid=0 or m_ready=1). Otherwise ccff_shift_en=0 and all state holds.
  - At word end:
    - m_data←captured word, with unused upper bits zero for a partial last word; m_valid←1.
    - If bit_cnt reaches CHAIN_LEN → DRAIN, else → FETCH.
  - Upper bits of a partial last input word are ignored.
- m_valid/m_ready:
  - Standard valid/ready handshake; m_valid holds with m_data stable until m_ready.
  - Transfer and refill in the same cycle is allowed.
- DRAIN:
  - Wait until m_valid=0, or until m_valid&&m_ready in this cycle.
  - Then → DONE.
- DONE:
  - done=1 for one cycle; IO_ISOL_N←1 (held until the next start or reset); → IDLE.
- Latency:
  - One bit per cycle when not stalled.
  - Minimum load time is CHAIN_LEN shift cycles, plus one FETCH cycle per word, plus DRAIN/DONE.
- Flow control:
  - ccff_shift_en is never high outside SHIFT.
  - No data-dependent shift while waiting on s_valid.
- s_valid low in FETCH: wait indefinitely with no timeout; the chain does not shift.

Test Plan:
1. Reset with the chain preloaded to 9'h1A5, then start, then send s_data=8'hC3 and 8'h01 with m_ready=1. Required response:
   - Exactly 9 ccff_shift_en cycles.
   - Chain then holds 9'h1C3 (bit0 first in = deepest position).
   - Readback 8'hA5 then 8'h01.
   - One done pulse; IO_ISOL_N goes 0→1.
2. Same load with s_valid gapped by 3 idle cycles between words → shift_en low during the gap; final chain contents and readback identical to scenario 1.
3. m_ready=0 held for 5 cycles when the first readback word completes. Required response:
   - shift_en drops on the 9th bit only after m_ready rises.
   - m_data=8'hA5 stable throughout.
   - No lost bits.
4. Last word s_data=8'hFF → only bit0 shifted; readback word 2 has bits[7:1]=0; bit_cnt=9 at done.
5. pReset_n pulsed low after 4 shifted bits. Required response:
   - All outputs 0 on the next cycle.
   - No done pulse; IO_ISOL_N stays 0.
   - A subsequent full load completes normally.
6. start asserted while busy, and start asserted in DONE → both ignored; exactly one load and one done pulse per accepted start.

Source files
------------

// File: rtl/ccff_chain_driver.sv
// Configuration-chain driver: serializes host words onto ccff_head, reads back the
// displaced chain contents from ccff_tail, and releases IO isolation after a full load.
module ccff_chain_driver #(
  parameter int unsigned CHAIN_LEN = 9,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int unsigned WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] rb;
  logic [WORD_W-1:0] rb_cap;
  logic [WB_W-1:0]   word_bit;
  logic              word_end;
  logic              last_bit;
  logic              out_free;

  assign last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign word_end = (word_bit == WB_W'(WORD_W - 1)) || last_bit;
  assign out_free = !m_valid || m_ready;

  // Readback word including the bit leaving the chain this cycle; upper bits stay zero.
  always_comb begin
    rb_cap           = rb;
    rb_cap[word_bit] = ccff_tail;
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    s_ready       = 1'b0;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        ccff_head = sreg[0];
        // A word-ending shift needs room in the readback register.
        ccff_shift_en = !word_end || out_free;
        if (ccff_shift_en && word_end) state_nxt = last_bit ? DRAIN : FETCH;
      end
      DRAIN: begin
        if (out_free) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      sreg      <= '0;
      rb        <= '0;
      word_bit  <= '0;
      bit_cnt   <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      IO_ISOL_N <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt   <= '0;
            IO_ISOL_N <= 1'b0;
          end
        end
        FETCH: begin
          if (s_valid) begin
            sreg     <= s_data;
            rb       <= '0;
            word_bit <= '0;
          end
        end
        SHIFT: begin
          if (ccff_shift_en) begin
            sreg     <= sreg >> 1;
            rb       <= rb_cap;
            word_bit <= word_bit + WB_W'(1);
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (word_end) begin
              m_data  <= rb_cap;
              m_valid <= 1'b1;
            end
          end
        end
        DONE: IO_ISOL_N <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_driver.sv
// Directed bench for ccff_chain_driver with a 9-bit behavioural chain looped back to ccff_tail.
module tb_ccff_chain_driver;

  localparam int unsigned CHAIN_LEN = 9;
  localparam int unsigned WORD_W    = 8;
  localparam int unsigned CNT_W     = 4;

  logic              prog_clk;
  logic              pReset_n;
  logic              start;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              IO_ISOL_N;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bit_cnt;

  int checks   = 0;
  int failures = 0;

  ccff_chain_driver #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W),
    .CNT_W    (CNT_W)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .IO_ISOL_N    (IO_ISOL_N),
    .busy         (busy),
    .done         (done),
    .bit_cnt      (bit_cnt)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Chain model: head enters the top, the first bit in ends up at position 0.
  logic [8:0] chain;
  logic [8:0] pre_val;
  logic       pre_req;
  assign ccff_tail = chain[0];
  always @(posedge prog_clk) begin
    if (pre_req)            chain <= pre_val;
    else if (ccff_shift_en) chain <= {ccff_head, chain[8:1]};
  end

  // Observed shifts, done pulses and accepted readback words.
  int         shift_cnt;
  int         done_cnt;
  int         rb_n;
  logic [7:0] rb_log [8];
  logic       clr;
  always @(negedge prog_clk) begin
    if (clr) begin
      shift_cnt <= 0;
      done_cnt  <= 0;
      rb_n      <= 0;
    end else begin
      if (ccff_shift_en) shift_cnt <= shift_cnt + 1;
      if (done)          done_cnt  <= done_cnt + 1;
      if (m_valid && m_ready && rb_n < 8) begin
        rb_log[rb_n] <= m_data;
        rb_n         <= rb_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic preload(input logic [8:0] v);
    pre_val = v;
    pre_req = 1'b1;
    tick();
    pre_req = 1'b0;
  endtask

  task automatic clr_mon();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 32'({ccff_shift_en, ccff_head, s_ready, m_valid, IO_ISOL_N, busy, done}), 32'd0);
    chk({tag, "_mdata"}, 32'(m_data), 32'd0);
    chk({tag, "_bitcnt"}, 32'(bit_cnt), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    int n;
    int sc;
    n = 0;
    if (gap > 0) begin
      while (!s_ready && n < 200) begin tick(); n++; end
      sc = shift_cnt;
      for (int i = 0; i < gap; i++) begin
        chk("gap_shift_en", 32'(ccff_shift_en), 32'd0);
        tick();
      end
      chk("gap_noshift", 32'(shift_cnt), 32'(sc));
    end
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 200) begin tick(); n++; end
    chk("s_ready_seen", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input int gap,
                          input bit start_busy);
    pulse_start();
    chk("isol_low", 32'(IO_ISOL_N), 32'd0);
    chk("busy_load", 32'(busy), 32'd1);
    send_word(w0, 0);
    if (start_busy) pulse_start();
    send_word(w1, gap);
  endtask

  task automatic wait_done(input bit start_in_done);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin tick(); n++; end
    chk("done_seen", 32'(done), 32'd1);
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_result(input string tag, input logic [8:0] exp_chain,
                              input logic [7:0] rb0, input logic [7:0] rb1);
    chk({tag, "_shifts"}, 32'(shift_cnt), 32'd9);
    chk({tag, "_chain"}, 32'(chain), 32'(exp_chain));
    chk({tag, "_rb_n"}, 32'(rb_n), 32'd2);
    chk({tag, "_rb0"}, 32'(rb_log[0]), 32'(rb0));
    chk({tag, "_rb1"}, 32'(rb_log[1]), 32'(rb1));
    chk({tag, "_dones"}, 32'(done_cnt), 32'd1);
    chk({tag, "_isol"}, 32'(IO_ISOL_N), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_bitcnt"}, 32'(bit_cnt), 32'd9);
  endtask

  initial begin
    int n;
    pReset_n = 1'b0;
    start    = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    m_ready  = 1'b1;
    pre_req  = 1'b0;
    pre_val  = '0;
    clr      = 1'b1;
    repeat (2) tick();

    // Reset with the chain preloaded
    preload(9'h1A5);
    repeat (2) tick();
    pReset_n = 1'b1;
    clr_mon();
    check_zero("rst");

    // Basic load
    run_load(8'hC3, 8'h01, 0, 1'b0);
    wait_done(1'b0);
    check_result("s1", 9'h1C3, 8'hA5, 8'h01);

    // Gapped s_valid between words
    preload(9'h1A5);
    clr_mon();
    run_load(8'hC3, 8'h01, 3, 1'b0);
    wait_done(1'b0);
    check_result("s2", 9'h1C3, 8'hA5, 8'h01);

    // Readback back-pressure stalls the ninth bit
    preload(9'h1A5);
    clr_mon();
    m_ready = 1'b0;
    run_load(8'hC3, 8'h01, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("s3_mdata_hold", 32'(m_data), 32'hA5);
      chk("s3_stall", 32'(ccff_shift_en), 32'd0);
      tick();
    end
    chk("s3_shifts_stalled", 32'(shift_cnt), 32'd8);
    m_ready = 1'b1;
    wait_done(1'b0);
    check_result("s3", 9'h1C3, 8'hA5, 8'h01);

    // Partial last word: only bit0 of 8'hFF enters the chain
    preload(9'h1A5);
    clr_mon();
    run_load(8'h3C, 8'hFF, 0, 1'b0);
    wait_done(1'b0);
    check_result("s4", 9'h13C, 8'hA5, 8'h01);

    // Reset mid-load
    preload(9'h1A5);
    clr_mon();
    pulse_start();
    send_word(8'hC3, 0);
    n = 0;
    while (shift_cnt < 4 && n < 50) begin tick(); n++; end
    chk("s5_four_shifted", 32'(shift_cnt), 32'd4);
    pReset_n = 1'b0;
    tick();
    check_zero("s5_rst");
    pReset_n = 1'b1;
    repeat (3) tick();
    chk("s5_no_done", 32'(done_cnt), 32'd0);
    chk("s5_isol", 32'(IO_ISOL_N), 32'd0);
    chk("s5_idle", 32'(busy), 32'd0);
    preload(9'h1A5);
    clr_mon();
    run_load(8'hC3, 8'h01, 0, 1'b0);
    wait_done(1'b0);
    check_result("s5_reload", 9'h1C3, 8'hA5, 8'h01);

    // start while busy and in DONE are ignored
    preload(9'h1A5);
    clr_mon();
    run_load(8'h5A, 8'h00, 0, 1'b1);
    wait_done(1'b1);
    repeat (3) tick();
    check_result("s6", 9'h05A, 8'hA5, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
